// File: rtl/mem_stream_pkg.sv
// Shared defaults and state encoding for the memory-to-AXI-Stream burst reader.
package mem_stream_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int LEN_WIDTH_DEF  = 13;
   localparam int FIFO_DEPTH     = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO between the memory read port and the stream output; head is
// presented combinationally so the consumer sees it the cycle after the push.
module axis_skid_fifo
   import mem_stream_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == 2'd2);
   assign empty     = (count_q == 2'd0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a burst of consecutive words from a one-cycle-latency memory and streams
// them out as an AXI-Stream master, issuing reads only when a FIFO slot is free.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; first read is issued in the start cycle
// ST_READ  | issuing remaining reads, throttled by FIFO credit
// ST_DRAIN | all reads issued, waiting for the tlast handshake
// ST_DONE  | one-cycle done pulse, then back to idle
module mem_stream_reader
   import mem_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                    m00_axis_aclk,
   input  logic                    m00_axis_aresetn,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [LEN_WIDTH-1:0]    length,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tvalid,
   input  logic                    m00_axis_tready,
   output logic                    m00_axis_tlast,
   output logic                    busy,
   output logic                    done
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic                    infl_q, infl_d;
   logic                    infl_last_q, infl_last_d;

   logic                    rd_en;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    last_issue;
   logic                    rd_ok;
   logic [2:0]              occ_after;

   logic [DATA_WIDTH:0]     fifo_head;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [1:0]              fifo_count;
   logic                    head_last;

   axis_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk       (m00_axis_aclk),
      .rst_n     (m00_axis_aresetn),
      .push      (fifo_push),
      .push_data ({infl_last_q, mem_rd_data}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head_last = fifo_head[DATA_WIDTH];
   assign fifo_pop  = m00_axis_tvalid && m00_axis_tready;
   assign fifo_push = infl_q && (!fifo_full || fifo_pop);

   // Credit counts the word leaving this cycle so tready=1 sustains one read per cycle.
   assign occ_after = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, fifo_pop};
   assign rd_ok     = (occ_after < 3'd2);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      rd_en      = 1'b0;
      rd_addr    = addr_q;
      last_issue = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_d = ST_DONE;
               end else begin
                  rd_en      = 1'b1;
                  rd_addr    = base_addr;
                  addr_d     = base_addr + ADDR_ONE;
                  rem_d      = length - LEN_ONE;
                  last_issue = (length == LEN_ONE);
                  state_d    = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (rem_q == '0) begin
               state_d = ST_DRAIN;
            end else if (rd_ok) begin
               rd_en      = 1'b1;
               addr_d     = addr_q + ADDR_ONE;
               rem_d      = rem_q - LEN_ONE;
               last_issue = (rem_q == LEN_ONE);
               if (rem_q == LEN_ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_pop && head_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      infl_d      = rd_en;
      infl_last_d = last_issue;
   end

   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
      if (!m00_axis_aresetn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
      end
   end

   assign mem_rd_en       = rd_en;
   assign mem_rd_addr     = rd_addr;
   assign m00_axis_tvalid = !fifo_empty;
   assign m00_axis_tdata  = m00_axis_tvalid ? fifo_head[DATA_WIDTH-1:0] : '0;
   assign m00_axis_tlast  = m00_axis_tvalid && head_last;
   assign m00_axis_tstrb  = {STRB_WIDTH{m00_axis_tvalid}};
   assign busy            = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done            = (state_q == ST_DONE);

endmodule
